// File: rtl/axioma_adc_trigger.sv
// ADC auto-trigger front end: picks one of eight trigger sources, detects rising edges,
// and issues one-cycle pulses to the ADC with a one-deep queue and miss accounting.
module axioma_adc_trigger #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       aden,
    input  logic       adate,
    input  logic [2:0] adts,
    input  logic       adif,
    input  logic       acomp_out,
    input  logic       int0_flag,
    input  logic       t0_compa,
    input  logic       t0_ovf,
    input  logic       t1_compb,
    input  logic       t1_ovf,
    input  logic       t1_capt,
    input  logic       adc_busy,
    input  logic       clear_status,
    output logic       adc_trigger,
    output logic       pending,
    output logic       trig_overrun,
    output logic       trig_timeout,
    output logic [7:0] miss_count,
    output logic [2:0] debug_state
);

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        ARMED    = 3'd1,
        FIRE     = 3'd2,
        WAIT_ACK = 3'd3,
        BUSY     = 3'd4
    } state_t;

    localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] acomp_sync;
    logic [2:0]             adts_q;
    logic                   prev;
    logic [7:0]             sources;
    logic                   enable;
    logic                   sel;
    logic                   edge_det;
    logic [7:0]             ack_cnt;
    logic [7:0]             ack_cnt_next;
    logic                   pending_next;
    logic                   miss;
    logic                   timeout_hit;

    assign enable  = aden & adate;
    assign sources = {t1_capt, t1_ovf, t1_compb, t0_ovf, t0_compa, int0_flag,
                      acomp_sync[SYNC_STAGES-1], adif};
    assign sel     = sources[adts];
    // A source switch only re-seeds prev, so a newly selected high level never fires.
    assign edge_det = enable & sel & ~prev & (adts == adts_q);
    assign debug_state = state;

    always_comb begin
        state_next   = state;
        pending_next = pending;
        ack_cnt_next = ack_cnt;
        miss         = 1'b0;
        timeout_hit  = 1'b0;
        if (!enable) begin
            state_next   = OFF;
            pending_next = 1'b0;
        end else begin
            case (state)
                OFF:      state_next = ARMED;
                ARMED:    if (edge_det) state_next = FIRE;
                FIRE: begin
                    ack_cnt_next = ACK_LOAD;
                    state_next   = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (adc_busy) begin
                        state_next = BUSY;
                    end else if (ack_cnt <= 8'd1) begin
                        ack_cnt_next = 8'd0;
                        timeout_hit  = 1'b1;
                        state_next   = ARMED;
                    end else begin
                        ack_cnt_next = ack_cnt - 8'd1;
                    end
                end
                BUSY:     if (!adc_busy) state_next = (pending | edge_det) ? FIRE : ARMED;
                default:  state_next = OFF;
            endcase

            // Queue edges that arrive while a trigger is in flight.
            if (state == FIRE || state == WAIT_ACK || state == BUSY) begin
                if (timeout_hit) begin
                    pending_next = 1'b0;
                end else if (state == BUSY && !adc_busy) begin
                    pending_next = pending & edge_det;
                end else if (edge_det) begin
                    if (pending) miss = 1'b1;
                    else         pending_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= OFF;
            acomp_sync   <= '0;
            adts_q       <= 3'd0;
            prev         <= 1'b0;
            ack_cnt      <= 8'd0;
            pending      <= 1'b0;
            adc_trigger  <= 1'b0;
            trig_overrun <= 1'b0;
            trig_timeout <= 1'b0;
            miss_count   <= 8'd0;
        end else begin
            state       <= state_next;
            acomp_sync  <= {acomp_sync[SYNC_STAGES-2:0], acomp_out};
            adts_q      <= adts;
            prev        <= sel;
            ack_cnt     <= ack_cnt_next;
            pending     <= pending_next;
            adc_trigger <= (state_next == FIRE);
            if (clear_status) begin
                trig_overrun <= 1'b0;
                trig_timeout <= 1'b0;
                miss_count   <= 8'd0;
            end else begin
                if (miss) begin
                    trig_overrun <= 1'b1;
                    if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                end
                if (timeout_hit) trig_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axioma_adc_trigger.sv
// Bench for axioma_adc_trigger: directed vector table, hand sequences for timing corners,
// and random stimulus checked each cycle against a behavioural model.
module tb_axioma_adc_trigger;
    localparam int SYNC = 2;
    localparam int ACK  = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       aden, adate, adc_busy, clear_status;
    logic [2:0] adts;
    logic [7:0] src;
    logic       adc_trigger, pending, trig_overrun, trig_timeout;
    logic [7:0] miss_count;
    logic [2:0] debug_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axioma_adc_trigger #(.SYNC_STAGES(SYNC), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .reset_n(reset_n), .aden(aden), .adate(adate), .adts(adts),
        .adif(src[0]), .acomp_out(src[1]), .int0_flag(src[2]), .t0_compa(src[3]),
        .t0_ovf(src[4]), .t1_compb(src[5]), .t1_ovf(src[6]), .t1_capt(src[7]),
        .adc_busy(adc_busy), .clear_status(clear_status),
        .adc_trigger(adc_trigger), .pending(pending), .trig_overrun(trig_overrun),
        .trig_timeout(trig_timeout), .miss_count(miss_count), .debug_state(debug_state)
    );

    // Model: trigger lifecycle as flags and a countdown, not as a state register.
    bit            m_on, m_pulse, m_conv, m_pend, m_ovr, m_to, m_prev;
    int            m_ack_wait, m_miss;
    logic [2:0]    m_adts_last;
    bit [SYNC-1:0] m_sync;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] dut_vec();
        return {adc_trigger, pending, trig_overrun, trig_timeout, miss_count, debug_state};
    endfunction

    function automatic logic [14:0] model_vec();
        logic [2:0] d;
        if (!m_on)               d = 3'd0;
        else if (m_pulse)        d = 3'd2;
        else if (m_ack_wait > 0) d = 3'd3;
        else if (m_conv)         d = 3'd4;
        else                     d = 3'd1;
        return {m_pulse, m_pend, m_ovr, m_to, 8'(m_miss), d};
    endfunction

    task automatic model_reset();
        m_on = 0; m_pulse = 0; m_conv = 0; m_pend = 0; m_ovr = 0; m_to = 0; m_prev = 0;
        m_ack_wait = 0; m_miss = 0; m_adts_last = 3'd0; m_sync = '0;
    endtask

    task automatic model_step();
        logic [7:0] lv;
        bit en, lvl, ev, miss, to;
        lv = src;
        lv[1] = m_sync[SYNC-1];
        lvl = lv[adts];
        en  = aden && adate;
        ev  = en && lvl && !m_prev && (adts == m_adts_last);
        m_prev = lvl;
        m_adts_last = adts;
        m_sync = {m_sync[SYNC-2:0], src[1]};
        miss = 0;
        to   = 0;
        if (!en) begin
            m_on = 0; m_pulse = 0; m_conv = 0; m_pend = 0; m_ack_wait = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (m_pulse) begin
            m_pulse = 0;
            m_ack_wait = ACK;
            miss = ev && m_pend; m_pend = m_pend || ev;
        end else if (m_ack_wait > 0) begin
            if (adc_busy) begin
                m_ack_wait = 0;
                m_conv = 1;
                miss = ev && m_pend; m_pend = m_pend || ev;
            end else if (m_ack_wait == 1) begin
                m_ack_wait = 0;
                m_pend = 0;
                to = 1;
            end else begin
                m_ack_wait--;
                miss = ev && m_pend; m_pend = m_pend || ev;
            end
        end else if (m_conv) begin
            if (adc_busy) begin
                miss = ev && m_pend; m_pend = m_pend || ev;
            end else begin
                m_conv = 0;
                if (m_pend || ev) m_pulse = 1;
                m_pend = m_pend && ev;
            end
        end else if (ev) begin
            m_pulse = 1;
        end
        if (clear_status) begin
            m_ovr = 0; m_to = 0; m_miss = 0;
        end else begin
            if (miss) begin
                m_ovr = 1;
                if (m_miss < 255) m_miss++;
            end
            if (to) m_to = 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    typedef struct packed {
        bit         en;
        logic [2:0] adts;
        logic [7:0] src;
        bit         busy;
        bit         clr;
        bit         trig;
        bit         pend;
        bit         ovr;
        logic [7:0] miss;
        logic [2:0] dbg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit en, logic [2:0] a, logic [7:0] s, bit b, bit c,
                                bit t, bit p, bit o, logic [7:0] m, logic [2:0] d);
        vec_t v;
        v.en = en; v.adts = a; v.src = s; v.busy = b; v.clr = c;
        v.trig = t; v.pend = p; v.ovr = o; v.miss = m; v.dbg = d;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; aden = 1'b0; adate = 1'b0; adts = 3'd0; src = 8'h00;
        adc_busy = 1'b0; clear_status = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", 32'(dut_vec()), 32'd0);
        reset_n = 1'b1;
        aden = 1'b1;

        // Timer0 overflow, then queue/overrun on Timer1 overflow, then disable and clear.
        //            en adts src    busy clr  trig pend ovr miss dbg
        tbl.push_back(mk(1, 4, 8'h00, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4, 8'h00, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4, 8'h10, 0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 4, 8'h00, 0, 0,  0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 4, 8'h00, 0, 0,  0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 4, 8'h00, 1, 0,  0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 4, 8'h00, 1, 0,  0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 4, 8'h00, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 4, 8'h00, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 6, 8'h40, 0, 0,  1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 6, 8'h00, 1, 0,  0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 6, 8'h40, 1, 0,  0, 1, 0, 0, 4));
        tbl.push_back(mk(1, 6, 8'h00, 1, 0,  0, 1, 0, 0, 4));
        tbl.push_back(mk(1, 6, 8'h40, 1, 0,  0, 1, 1, 1, 4));
        tbl.push_back(mk(1, 6, 8'h00, 1, 0,  0, 1, 1, 1, 4));
        tbl.push_back(mk(1, 6, 8'h40, 1, 0,  0, 1, 1, 2, 4));
        tbl.push_back(mk(1, 6, 8'h00, 1, 0,  0, 1, 1, 2, 4));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  1, 0, 1, 2, 2));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  0, 0, 1, 2, 3));
        tbl.push_back(mk(1, 6, 8'h00, 1, 0,  0, 0, 1, 2, 4));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 6, 8'h40, 0, 0,  1, 0, 1, 2, 2));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  0, 0, 1, 2, 3));
        tbl.push_back(mk(1, 6, 8'h40, 1, 0,  0, 1, 1, 2, 4));
        tbl.push_back(mk(1, 6, 8'h00, 1, 0,  0, 1, 1, 2, 4));
        tbl.push_back(mk(0, 6, 8'h00, 1, 0,  0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 6, 8'h00, 0, 0,  0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 6, 8'h00, 0, 1,  0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            adate = tbl[i].en; adts = tbl[i].adts; src = tbl[i].src;
            adc_busy = tbl[i].busy; clear_status = tbl[i].clr;
            cycle();
            check($sformatf("vec%0d", i),
                  32'({adc_trigger, pending, trig_overrun, miss_count, debug_state}),
                  32'({tbl[i].trig, tbl[i].pend, tbl[i].ovr, tbl[i].miss, tbl[i].dbg}));
        end
        clear_status = 1'b0;

        // Acknowledge timeout on Timer0 compare A.
        adts = 3'd3; src = 8'h00; cycle();
        src = 8'h08; cycle();
        check("tp3_fire", 32'(adc_trigger), 32'd1);
        src = 8'h00;
        for (int k = 1; k <= ACK; k++) begin
            cycle();
            check($sformatf("tp3_wait%0d", k), 32'({trig_timeout, debug_state}), 32'({1'b0, 3'd3}));
        end
        cycle();
        check("tp3_timeout", 32'({adc_trigger, trig_timeout, debug_state}), 32'({1'b0, 1'b1, 3'd1}));
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("tp3_no_refire", 32'(adc_trigger), 32'd0);
        end

        // Switching onto an already-high source must not fire.
        adts = 3'd0; src = 8'h80; cycle(); cycle();
        adts = 3'd7;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("tp4_switch_quiet", 32'({adc_trigger, debug_state}), 32'({1'b0, 3'd1}));
        end
        src = 8'h00; cycle();
        check("tp4_fall", 32'(adc_trigger), 32'd0);
        src = 8'h80; cycle();
        check("tp4_refire", 32'(adc_trigger), 32'd1);
        cycle();
        adc_busy = 1'b1; cycle();
        adc_busy = 1'b0; cycle();
        check("tp4_done", 32'({adc_trigger, debug_state}), 32'({1'b0, 3'd1}));

        // Free-running: ADIF rise retriggers, software clear of ADIF does not.
        adts = 3'd0; src = 8'h00; cycle();
        src = 8'h01; cycle();
        check("free_fire", 32'(adc_trigger), 32'd1);
        cycle();
        adc_busy = 1'b1; cycle();
        adc_busy = 1'b0; src = 8'h00; cycle();
        cycle();
        check("free_clear_quiet", 32'({adc_trigger, debug_state}), 32'({1'b0, 3'd1}));

        // Comparator path adds the synchronizer depth.
        adts = 3'd1; src = 8'h00; repeat (3) cycle();
        src = 8'h02; cycle();
        check("tp5_plus1", 32'(adc_trigger), 32'd0);
        cycle();
        check("tp5_plus2", 32'(adc_trigger), 32'd0);
        cycle();
        check("tp5_plus3", 32'(adc_trigger), 32'd1);
        cycle();
        adc_busy = 1'b1; cycle();
        adc_busy = 1'b0; cycle();

        // Asynchronous reset while in FIRE with the timeout flag still set.
        adts = 3'd5; src = 8'h00; cycle();
        src = 8'h20; cycle();
        check("tp6_fire", 32'({adc_trigger, trig_timeout}), 32'({1'b1, 1'b1}));
        reset_n = 1'b0;
        #1;
        check("tp6_async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("tp6_no_pulse_after_reset", 32'(adc_trigger), 32'd0);
        end

        // Miss counter saturation, then a clear that coincides with a miss.
        adts = 3'd2; src = 8'h00; cycle();
        src = 8'h04; cycle();
        src = 8'h00; cycle();
        adc_busy = 1'b1;
        for (int k = 0; k < 260; k++) begin
            src = 8'h04; cycle();
            src = 8'h00; cycle();
        end
        check("sat_miss", 32'({trig_overrun, pending, miss_count}), 32'({1'b1, 1'b1, 8'd255}));
        src = 8'h04; clear_status = 1'b1; cycle();
        check("clear_wins", 32'({trig_overrun, pending, miss_count}), 32'({1'b0, 1'b1, 8'd0}));
        clear_status = 1'b0; src = 8'h00; adc_busy = 1'b0; cycle();
        check("queued_fire", 32'(adc_trigger), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            aden  = ($urandom_range(0, 199) != 0);
            adate = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 49) == 0) adts = 3'($urandom_range(0, 7));
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) src[b] = ~src[b];
            if ($urandom_range(0, 3) == 0) adc_busy = ~adc_busy;
            clear_status = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
